// File: rtl/mod_counter_pkg.sv
// Shared types and next-count function for the modulo-N up/down counter.
// Define MOD_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
package mod_counter_pkg;

   typedef enum logic [2:0] {LOAD, LOAD_BAD, INC, DEC, HOLD} cnt_op_e;

   // Operates on 32-bit values; modulus is 33 bits so 2**32 is representable.
   function automatic logic [31:0] f_next(input logic [31:0] q,
                                          input cnt_op_e     op,
                                          input logic [32:0] modulus,
                                          input logic [31:0] load_val);
      logic [31:0] top;
      top    = modulus[31:0] - 32'd1;
      f_next = q;
      case (op)
         LOAD: f_next = load_val;
`ifdef MOD_COUNTER_SATURATE_EN
         INC:  f_next = (q == top)   ? q : q + 32'd1;
         DEC:  f_next = (q == 32'd0) ? q : q - 32'd1;
`else
         INC:  f_next = (q == top)   ? 32'd0 : q + 32'd1;
         DEC:  f_next = (q == 32'd0) ? top   : q - 32'd1;
`endif
         default: f_next = q;
      endcase
   endfunction

endpackage

// File: rtl/mod_counter_decode.sv
// Priority decode of load/en/up_dn/load_val into the per-cycle counter operation.
module mod_counter_decode
   import mod_counter_pkg::*;
#(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic             load,
   input  logic             en,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] load_val,
   output cnt_op_e          op
);

   localparam logic [32:0] MOD33 = 33'(MODULUS);

   logic load_bad;
   assign load_bad = (33'(load_val) >= MOD33);

   always_comb begin
      op = HOLD;
      if (load)      op = load_bad ? LOAD_BAD : LOAD;
      else if (en)   op = up_dn ? INC : DEC;
   end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with load, terminal count and wrap/load-error pulses.
// Build with MOD_COUNTER_SATURATE_EN defined to saturate at the bounds instead of wrapping.
module mod_n_updown_counter
   import mod_counter_pkg::*;
#(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
       MODULUS > (longint'(1) << WIDTH)) begin : g_bad_param
      $error("mod_n_updown_counter: illegal WIDTH/MODULUS combination");
   end

   localparam logic [32:0]      MOD33 = 33'(MODULUS);
   localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);

   cnt_op_e          op;
   logic [WIDTH-1:0] q_next;
   logic             at_bound;

   mod_counter_decode #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_decode (
      .load     (load),
      .en       (en),
      .up_dn    (up_dn),
      .load_val (load_val),
      .op       (op)
   );

   assign q_next = WIDTH'(f_next(32'(q), op, MOD33, 32'(load_val)));

   // Same condition flags a wrap or, in saturating builds, a hold at the bound.
   assign at_bound = ((op == INC) && (q == MAXV)) ||
                     ((op == DEC) && (q == '0));

   assign tc = en & ((up_dn & (q == MAXV)) | (~up_dn & (q == '0)));

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         wrap     <= at_bound;
         load_err <= (op == LOAD_BAD);
      end
   end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter (WIDTH=4, MODULUS=10) plus a two-digit cascade.
module tb_mod_n_updown_counter;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         clear = 1'b1;
   logic         en = 1'b0, up_dn = 1'b0, load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] q;
   logic         tc, wrap, load_err;

   logic         cas_clear = 1'b1;
   logic         cas_en = 1'b0;
   logic [W-1:0] q_lo, q_hi;
   logic         tc_lo, tc_hi, wrap_lo, wrap_hi, err_lo, err_hi;

   int checks = 0;
   int errors = 0;

   // model state, derived directly from the counting rules
   int   m_q = 0;
   logic m_wrap = 1'b0;
   logic m_err = 1'b0;

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk(clk), .clear(clear), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
   );

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
      .clk(clk), .clear(cas_clear), .en(cas_en), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .load_err(err_lo)
   );

   mod_n_updown_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
      .clk(clk), .clear(cas_clear), .en(tc_lo), .up_dn(1'b1), .load(1'b0),
      .load_val(4'd0), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .load_err(err_hi)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference behaviour
   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         m_q = 0; m_wrap = 1'b0; m_err = 1'b0;
      end else if (load) begin
         m_wrap = 1'b0;
         if (int'(load_val) < M) begin m_q = int'(load_val); m_err = 1'b0; end
         else m_err = 1'b1;
      end else if (en) begin
         m_err = 1'b0;
         if (up_dn) begin
            m_wrap = (m_q == M - 1);
`ifdef MOD_COUNTER_SATURATE_EN
            if (m_q != M - 1) m_q = m_q + 1;
`else
            m_q = (m_q + 1) % M;
`endif
         end else begin
            m_wrap = (m_q == 0);
`ifdef MOD_COUNTER_SATURATE_EN
            if (m_q != 0) m_q = m_q - 1;
`else
            m_q = (m_q + M - 1) % M;
`endif
         end
      end else begin
         m_wrap = 1'b0; m_err = 1'b0;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      check("q_vs_model", 32'(q), 32'(m_q));
      check("wrap_vs_model", 32'(wrap), 32'(m_wrap));
      check("load_err_vs_model", 32'(load_err), 32'(m_err));
      check("tc_vs_model", 32'(tc),
            32'(en & ((up_dn & (m_q == M - 1)) | (~up_dn & (m_q == 0)))));
      check("q_in_range", 32'(int'(q) < M), 32'd1);
   end

   // apply inputs for the coming edge, return just after the following negedge
   task automatic cyc(input logic e, input logic ud, input logic ld, input logic [W-1:0] lv);
      en = e; up_dn = ud; load = ld; load_val = lv;
      @(negedge clk); #1;
   endtask

   initial begin
      #2 clear = 1'b0; cas_clear = 1'b0;
      repeat (3) @(negedge clk);
      #1 clear = 1'b1; cas_clear = 1'b1;
      check("reset_q", 32'(q), 32'd0);
      check("reset_wrap", 32'(wrap), 32'd0);
      check("reset_load_err", 32'(load_err), 32'd0);

      // up count through the wrap
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'd0);
         check("up_q", 32'(q), (k == 10) ? 32'd0 : 32'(k));
         check("up_wrap", 32'(wrap), (k == 10) ? 32'd1 : 32'd0);
         check("up_tc", 32'(tc), (k == 9) ? 32'd1 : 32'd0);
      end

      // down from zero
      en = 1'b1; up_dn = 1'b0; #1;
      check("down_tc_at_0", 32'(tc), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
`ifdef MOD_COUNTER_SATURATE_EN
      check("down_sat_q", 32'(q), 32'd0);
      check("down_sat_wrap", 32'(wrap), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      check("down_sat_q2", 32'(q), 32'd0);
      check("down_sat_wrap2", 32'(wrap), 32'd1);
`else
      check("down_wrap_q", 32'(q), 32'd9);
      check("down_wrap_pulse", 32'(wrap), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      check("down_q8", 32'(q), 32'd8);
      check("down_wrap_clear", 32'(wrap), 32'd0);
`endif

      // load wins over count; out-of-range load holds and flags
      cyc(1'b1, 1'b1, 1'b1, 4'd5);
      check("load5_q", 32'(q), 32'd5);
      check("load5_err", 32'(load_err), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 4'd12);
      check("load12_q", 32'(q), 32'd5);
      check("load12_err", 32'(load_err), 32'd1);
      cyc(1'b0, 1'b1, 1'b0, 4'd0);
      check("load12_err_drop", 32'(load_err), 32'd0);
      check("hold_q", 32'(q), 32'd5);

      // asynchronous clear mid-cycle while counting
      cyc(1'b0, 1'b1, 1'b1, 4'd7);
      check("load7_q", 32'(q), 32'd7);
      en = 1'b1; up_dn = 1'b1; load = 1'b0;
      #1 clear = 1'b0;
      #1;
      check("async_clear_q", 32'(q), 32'd0);
      check("async_clear_wrap", 32'(wrap), 32'd0);
      check("async_clear_err", 32'(load_err), 32'd0);
      clear = 1'b1;
      @(negedge clk); #1;
      check("count_after_clear", 32'(q), 32'd1);

`ifndef MOD_COUNTER_SATURATE_EN
      // two-digit cascade 00..99 then 00
      cas_en = 1'b1;
      #1;
      for (int n = 0; n <= 100; n++) begin
         check("cascade_value", 32'(int'(q_hi) * 10 + int'(q_lo)), 32'(n % 100));
         check("cascade_hi_tc", 32'(tc_hi), (n == 99) ? 32'd1 : 32'd0);
         @(negedge clk); #2;
      end
      cas_en = 1'b0;
`endif

      // random traffic with occasional asynchronous clears
      for (int i = 0; i < 10000; i++) begin
         clear = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 9) == 0), W'($urandom_range(0, 15)));
      end
      clear = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
